// File: rtl/pdm_capture_ctrl_if.sv
// Sample/read-side bundle between the decimator, the capture controller and the host register block.
// The DUT takes the slave modport; the host/decimator model takes the master modport.
interface pdm_capture_ctrl_if #(
    parameter int SAMPLE_DEPTH = 16,
    parameter int FIFO_DEPTH   = 16
);
    localparam int LVL_W = $clog2(FIFO_DEPTH + 1);

    logic signed [SAMPLE_DEPTH-1:0] in_sample;
    logic                           in_valid;
    logic                           rd_en;
    logic signed [SAMPLE_DEPTH-1:0] rd_data;
    logic                           rd_valid;
    logic [LVL_W-1:0]               level;
    logic                           wm_irq;
    logic                           overflow;
    logic                           overflow_clr;

    modport master (
        output in_sample, in_valid, rd_en, overflow_clr,
        input  rd_data, rd_valid, level, wm_irq, overflow
    );

    modport slave (
        input  in_sample, in_valid, rd_en, overflow_clr,
        output rd_data, rd_valid, level, wm_irq, overflow
    );
endinterface

// File: rtl/pdm_capture_ctrl.sv
// PDM capture sequencer: mic power gating, warmup discard and sample FIFO with read handshake.
// Optional DC removal (one extra cycle of push latency) is built when MIC_DC_REMOVE_EN is defined.
module pdm_capture_ctrl #(
    parameter int SAMPLE_DEPTH   = 16,
    parameter int FIFO_DEPTH     = 16,
    parameter int WARMUP_SAMPLES = 4,
    parameter int WATERMARK      = 8,
    parameter int DC_SHIFT       = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    output logic                    mic_en,
    output logic                    running,
    pdm_capture_ctrl_if.slave       bus
);
    localparam int LVL_W = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int WU_W  = (WARMUP_SAMPLES > 0) ? $clog2(WARMUP_SAMPLES + 1) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WARMUP = 2'd1,
        ST_RUN    = 2'd2
    } state_t;

    state_t                  state_r, next_state_s;
    logic [WU_W-1:0]         wu_cnt_r;
    logic [PTR_W-1:0]        wr_ptr_r, rd_ptr_r;
    logic [LVL_W-1:0]        level_r, level_nxt_s;
    logic [SAMPLE_DEPTH-1:0] mem_r [FIFO_DEPTH];
    logic [SAMPLE_DEPTH-1:0] rd_data_r;
    logic                    rd_valid_r, wm_irq_r, overflow_r;
    logic                    flush_s, push_req_s, push_s, pop_s, drop_s, full_s;
    logic [SAMPLE_DEPTH-1:0] push_data_s;

`ifdef MIC_DC_REMOVE_EN
    localparam int ACC_W = SAMPLE_DEPTH + DC_SHIFT;

    logic signed [ACC_W-1:0]        dc_acc_r, dc_est_s;
    logic signed [SAMPLE_DEPTH:0]   diff_s;
    logic                           dly_valid_r;
    logic [SAMPLE_DEPTH-1:0]        dly_data_r;

    function automatic logic [SAMPLE_DEPTH-1:0] sat_fn(input logic signed [SAMPLE_DEPTH:0] v);
        if (v[SAMPLE_DEPTH] != v[SAMPLE_DEPTH-1]) begin
            return v[SAMPLE_DEPTH] ? {1'b1, {(SAMPLE_DEPTH-1){1'b0}}} : {1'b0, {(SAMPLE_DEPTH-1){1'b1}}};
        end else begin
            return v[SAMPLE_DEPTH-1:0];
        end
    endfunction

    // dc_est always fits the sample range, so its low SAMPLE_DEPTH+1 bits are exact.
    assign dc_est_s = dc_acc_r >>> DC_SHIFT;
    assign diff_s   = $signed({bus.in_sample[SAMPLE_DEPTH-1], bus.in_sample}) - $signed(dc_est_s[SAMPLE_DEPTH:0]);

    // DC tracker and the one-stage delay that carries the corrected sample to the FIFO
    always_ff @(posedge clk) begin
        if (rst) begin
            dc_acc_r    <= '0;
            dly_valid_r <= 1'b0;
            dly_data_r  <= '0;
        end else begin
            if (bus.in_valid && (state_r != ST_IDLE)) begin
                dc_acc_r <= dc_acc_r + ACC_W'(diff_s);
            end
            dly_valid_r <= bus.in_valid && (state_r == ST_RUN);
            dly_data_r  <= sat_fn(diff_s);
        end
    end

    assign push_req_s  = dly_valid_r;
    assign push_data_s = dly_data_r;
`else
    assign push_req_s  = bus.in_valid && (state_r == ST_RUN);
    assign push_data_s = bus.in_sample;
`endif

    assign flush_s = (state_r == ST_IDLE) && enable;
    assign pop_s   = bus.rd_en && (level_r != {LVL_W{1'b0}});
    assign full_s  = (level_r == LVL_W'(FIFO_DEPTH));
    assign push_s  = push_req_s && (!full_s || pop_s);
    assign drop_s  = push_req_s && !push_s;

    // Next-state decode; a zero warmup count leaves WARMUP on the first cycle
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (enable) next_state_s = ST_WARMUP;
                else        next_state_s = ST_IDLE;
            end
            ST_WARMUP: begin
                if (!enable)                                          next_state_s = ST_IDLE;
                else if (wu_cnt_r == {WU_W{1'b0}})                    next_state_s = ST_RUN;
                else if (bus.in_valid && (wu_cnt_r == WU_W'(1)))      next_state_s = ST_RUN;
                else                                                  next_state_s = ST_WARMUP;
            end
            ST_RUN: begin
                if (!enable) next_state_s = ST_IDLE;
                else         next_state_s = ST_RUN;
            end
            default: next_state_s = ST_IDLE;
        endcase
    end

    // Occupancy after this cycle's flush/push/pop
    always_comb begin
        level_nxt_s = level_r;
        if (flush_s)              level_nxt_s = {LVL_W{1'b0}};
        else if (push_s && !pop_s) level_nxt_s = level_r + LVL_W'(1);
        else if (pop_s && !push_s) level_nxt_s = level_r - LVL_W'(1);
        else                       level_nxt_s = level_r;
    end

    // Sequencer state with registered enable/running decodes and warmup counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            mic_en   <= 1'b0;
            running  <= 1'b0;
            wu_cnt_r <= '0;
        end else begin
            state_r <= next_state_s;
            mic_en  <= (next_state_s != ST_IDLE);
            running <= (next_state_s == ST_RUN);
            if (flush_s) begin
                wu_cnt_r <= WU_W'(WARMUP_SAMPLES);
            end else if ((state_r == ST_WARMUP) && bus.in_valid && (wu_cnt_r != {WU_W{1'b0}})) begin
                wu_cnt_r <= wu_cnt_r - WU_W'(1);
            end
        end
    end

    // Sample storage; a flush discards anything arriving on the same edge
    always_ff @(posedge clk) begin
        if (push_s && !flush_s) begin
            mem_r[wr_ptr_r] <= push_data_s;
        end
    end

    // FIFO pointers, level, read port and status flags
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            level_r    <= '0;
            wm_irq_r   <= 1'b0;
            rd_data_r  <= '0;
            rd_valid_r <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            if (flush_s) begin
                wr_ptr_r <= '0;
                rd_ptr_r <= '0;
            end else begin
                if (push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
                if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            level_r    <= level_nxt_s;
            wm_irq_r   <= (level_nxt_s >= LVL_W'(WATERMARK));
            rd_valid_r <= pop_s;
            if (pop_s) rd_data_r <= mem_r[rd_ptr_r];
            if (drop_s)                overflow_r <= 1'b1;
            else if (bus.overflow_clr) overflow_r <= 1'b0;
        end
    end

    assign bus.level    = level_r;
    assign bus.wm_irq   = wm_irq_r;
    assign bus.rd_data  = rd_data_r;
    assign bus.rd_valid = rd_valid_r;
    assign bus.overflow = overflow_r;

endmodule

// File: tb/tb_pdm_capture_ctrl.sv
// Directed self-checking bench for pdm_capture_ctrl with hand-computed expectations.
module tb_pdm_capture_ctrl;
    logic clk = 1'b0;
    logic rst;
    logic enable;
    logic mic_en;
    logic running;
    int   n_checks = 0;
    int   n_fail   = 0;

    pdm_capture_ctrl_if #(.SAMPLE_DEPTH(16), .FIFO_DEPTH(16)) bus ();

    pdm_capture_ctrl dut (
        .clk     (clk),
        .rst     (rst),
        .enable  (enable),
        .mic_en  (mic_en),
        .running (running),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int val);
        bus.in_sample = 16'(val);
        bus.in_valid  = 1'b1;
        tick();
        bus.in_valid  = 1'b0;
    endtask

    task automatic pop(output int val);
        bus.rd_en = 1'b1;
        tick();
        bus.rd_en = 1'b0;
        val = int'(bus.rd_data);
    endtask

    task automatic pop_check(input string tag, input int exp);
        int v;
        pop(v);
        check_eq({tag, "_valid"}, 32'(bus.rd_valid), 32'd1);
        check_eq(tag, 32'(v), 32'(exp));
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, "_mic_en"},   32'(mic_en),       32'd0);
        check_eq({tag, "_running"},  32'(running),      32'd0);
        check_eq({tag, "_rd_valid"}, 32'(bus.rd_valid), 32'd0);
        check_eq({tag, "_rd_data"},  32'(bus.rd_data),  32'd0);
        check_eq({tag, "_level"},    32'(bus.level),    32'd0);
        check_eq({tag, "_wm_irq"},   32'(bus.wm_irq),   32'd0);
        check_eq({tag, "_overflow"}, 32'(bus.overflow), 32'd0);
    endtask

    initial begin
        int v;
        rst = 1'b1; enable = 1'b0;
        bus.in_sample = '0; bus.in_valid = 1'b0; bus.rd_en = 1'b0; bus.overflow_clr = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check_reset_state("reset");

`ifdef MIC_DC_REMOVE_EN
        enable = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) push(1000);
        check_eq("dc_running", 32'(running), 32'd1);
        for (int i = 0; i < 16; i++) begin
            push(1000);
            tick();
        end
        check_eq("dc_level", 32'(bus.level), 32'd16);
        pop_check("dc_first", 939);
        for (int i = 0; i < 15; i++) pop(v);
        check_eq("dc_trend", 32'(v < 939 && v >= 0), 32'd1);
`else
        // warmup discard: 1..4 dropped, 5 and 6 kept
        enable = 1'b1;
        tick();
        check_eq("wu_mic_en", 32'(mic_en), 32'd1);
        check_eq("wu_running0", 32'(running), 32'd0);
        for (int i = 1; i <= 3; i++) push(i);
        check_eq("wu_running3", 32'(running), 32'd0);
        push(4);
        check_eq("wu_running4", 32'(running), 32'd1);
        check_eq("wu_level4", 32'(bus.level), 32'd0);
        push(5);
        push(6);
        check_eq("wu_level", 32'(bus.level), 32'd2);
        pop_check("wu_pop5", 5);
        pop_check("wu_pop6", 6);
        check_eq("wu_level_end", 32'(bus.level), 32'd0);

        // empty read holds data
        bus.rd_en = 1'b1;
        tick();
        bus.rd_en = 1'b0;
        check_eq("empty_valid", 32'(bus.rd_valid), 32'd0);
        check_eq("empty_data", 32'(bus.rd_data), 32'd6);
        check_eq("empty_level", 32'(bus.level), 32'd0);

        // fill past capacity
        for (int i = 0; i < 17; i++) begin
            push(100 + i);
            if (i == 6) check_eq("wm_below", 32'(bus.wm_irq), 32'd0);
            if (i == 7) check_eq("wm_at", 32'(bus.wm_irq), 32'd1);
            if (i == 15) check_eq("ovf_not_yet", 32'(bus.overflow), 32'd0);
        end
        check_eq("ovf_level", 32'(bus.level), 32'd16);
        check_eq("ovf_flag", 32'(bus.overflow), 32'd1);
        check_eq("ovf_wm", 32'(bus.wm_irq), 32'd1);
        bus.overflow_clr = 1'b1;
        push(999);
        bus.overflow_clr = 1'b0;
        check_eq("ovf_set_wins", 32'(bus.overflow), 32'd1);
        pop_check("ovf_first", 100);
        for (int i = 1; i < 15; i++) pop(v);
        pop_check("ovf_last", 115);
        check_eq("ovf_level0", 32'(bus.level), 32'd0);
        check_eq("ovf_wm0", 32'(bus.wm_irq), 32'd0);
        bus.overflow_clr = 1'b1;
        tick();
        bus.overflow_clr = 1'b0;
        check_eq("ovf_clr", 32'(bus.overflow), 32'd0);

        // full with simultaneous push and pop
        for (int i = 0; i < 16; i++) push(200 + i);
        check_eq("fpp_full", 32'(bus.level), 32'd16);
        bus.in_sample = 16'd300; bus.in_valid = 1'b1; bus.rd_en = 1'b1;
        tick();
        bus.in_valid = 1'b0; bus.rd_en = 1'b0;
        check_eq("fpp_data", 32'(bus.rd_data), 32'd200);
        check_eq("fpp_level", 32'(bus.level), 32'd16);
        check_eq("fpp_ovf", 32'(bus.overflow), 32'd0);
        pop_check("fpp_head", 201);
        for (int i = 2; i < 16; i++) pop(v);
        pop_check("fpp_tail", 300);
        check_eq("fpp_empty", 32'(bus.level), 32'd0);

        // disable keeps contents readable
        push(1); push(2); push(3);
        enable = 1'b0;
        tick();
        check_eq("dis_mic_en", 32'(mic_en), 32'd0);
        check_eq("dis_running", 32'(running), 32'd0);
        check_eq("dis_level", 32'(bus.level), 32'd3);
        pop_check("dis_pop1", 1);
        pop_check("dis_pop2", 2);
        pop_check("dis_pop3", 3);

        // re-enable flushes a level of 2; IDLE ignores samples
        enable = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) push(50);
        push(7); push(8);
        enable = 1'b0;
        tick();
        push(9);
        check_eq("idle_ignore", 32'(bus.level), 32'd2);
        enable = 1'b1;
        tick();
        check_eq("reen_flush", 32'(bus.level), 32'd0);
        check_eq("reen_mic_en", 32'(mic_en), 32'd1);

        // reset mid-run with level 5 and overflow set
        for (int i = 0; i < 4; i++) push(50);
        for (int i = 0; i < 17; i++) push(400 + i);
        for (int i = 0; i < 11; i++) pop(v);
        check_eq("mid_level", 32'(bus.level), 32'd5);
        check_eq("mid_ovf", 32'(bus.overflow), 32'd1);
        check_eq("mid_running", 32'(running), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        enable = 1'b0;
        check_reset_state("mid_rst");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
